// File: rtl/seg_digit_scanner_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
// Holds the slot FSM encoding, anode patterns and a width helper.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    S_BLANK0 = 2'd0,
    S_SHOW0  = 2'd1,
    S_BLANK1 = 2'd2,
    S_SHOW1  = 2'd3
  } state_e;

  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_digit_scanner_if.sv
// Load/ack handshake plus mux and anode drive for the digit scanner.
// The scanner takes the slave side; whoever supplies values takes master.
interface seg_digit_scanner_if;
  logic       load;
  logic [7:0] value;
  logic       lz_blank;
  logic       load_ack;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel;
  logic [1:0] an_n;
  logic       tick;

  modport master (
    output load, value, lz_blank,
    input  load_ack, a, b, sel, an_n, tick
  );

  modport slave (
    input  load, value, lz_blank,
    output load_ack, a, b, sel, an_n, tick
  );
endinterface

// File: rtl/seg_digit_scanner_slot_timer.sv
// Free-running slot counter for the digit scanner: counts 0..PRESCALE-1
// and flags the end of the blank phase and the last clock of the slot.
module slot_timer
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16,
  parameter int CW       = clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_o,
  output logic          blank_done_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q;

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == CW'(PRESCALE - 1));
  // With no blank interval the show phase may begin at once.
  assign blank_done_o = (BLANK == 0) ? 1'b1 : (cnt_q == CW'(BLANK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (wrap_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg_digit_scanner.sv
// Two-digit seven-segment scan controller: double-buffered value capture,
// mux select and active-low anodes with a blank interval per digit slot.
module seg_digit_scanner
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input logic                clk,
  input logic                rst_n,
  seg_digit_scanner_if.slave bus_if
);

  localparam int CW = clog2(PRESCALE);

  logic [CW-1:0] cnt;
  logic          blank_done;
  logic          wrap;

  slot_timer #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK),
    .CW       (CW)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_o        (cnt),
    .blank_done_o (blank_done),
    .wrap_o       (wrap)
  );

  state_e     state_q;
  logic       sel_q;
  logic [1:0] an_q;
  logic [3:0] a_q, b_q;
  logic [7:0] pend_q;
  logic       pend_v_q;
  logic       ack_q;
  logic       tick_q;
  logic       commit;

  assign commit = (state_q == S_SHOW1) && wrap;

  // Slot FSM; sel and anodes are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK0;
      sel_q   <= 1'b0;
      an_q    <= AN_OFF;
    end else begin
      case (state_q)
        S_BLANK0: if (blank_done) begin
          state_q <= S_SHOW0;
          an_q    <= AN_D0;
        end
        S_SHOW0: if (wrap) begin
          sel_q <= 1'b1;
          if (BLANK == 0) begin
            state_q <= S_SHOW1;
            an_q    <= AN_D1;
          end else begin
            state_q <= S_BLANK1;
            an_q    <= AN_OFF;
          end
        end
        S_BLANK1: if (blank_done) begin
          state_q <= S_SHOW1;
          an_q    <= AN_D1;
        end
        S_SHOW1: if (wrap) begin
          sel_q <= 1'b0;
          if (BLANK == 0) begin
            state_q <= S_SHOW0;
            an_q    <= AN_D0;
          end else begin
            state_q <= S_BLANK0;
            an_q    <= AN_OFF;
          end
        end
        default: begin
          state_q <= S_BLANK0;
          sel_q   <= 1'b0;
          an_q    <= AN_OFF;
        end
      endcase
    end
  end

  // Handshake and double buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ack_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      ack_q  <= bus_if.load;
      // Counter reaches PRESCALE-1 on the next edge exactly when it is at PRESCALE-2 now.
      tick_q <= (cnt == CW'(PRESCALE - 2));
      // NOTE: non-blocking assignments let a commit and a load share an edge:
      // the commit reads the old pend_q while the new value replaces it.
      if (commit && pend_v_q) begin
        {b_q, a_q} <= pend_q;
      end
      if (bus_if.load) begin
        pend_q   <= bus_if.value;
        pend_v_q <= 1'b1;
      end else if (commit) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign bus_if.load_ack = ack_q;
  assign bus_if.a        = a_q;
  assign bus_if.b        = b_q;
  assign bus_if.sel      = sel_q;
  assign bus_if.tick     = tick_q;
  // Leading-zero suppression of digit 1 follows lz_blank within the same cycle.
  assign bus_if.an_n = (state_q == S_SHOW1 && bus_if.lz_blank && b_q == 4'd0)
                       ? AN_OFF : an_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: directed handshake/commit scenarios and a
// random phase, checked every cycle against a frame-level reference model.
module tb_seg_digit_scanner;

  localparam int P = 8;
  localparam int B = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg_digit_scanner_if bus_if ();

  seg_digit_scanner #(
    .PRESCALE (P),
    .BLANK    (B)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state: cycles since reset release, shown value, pending buffer.
  int         t;
  logic [7:0] m_disp;
  logic [7:0] m_pend;
  logic       m_pv;
  logic       m_ack;
  logic       m_lz;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic check_model();
    int         pos;
    int         slot;
    logic [1:0] e_an;
    pos  = t % P;
    slot = (t / P) % 2;
    if (pos < B)                           e_an = 2'b11;
    else if (slot == 0)                    e_an = 2'b10;
    else if (m_lz && m_disp[7:4] == 4'h0)  e_an = 2'b11;
    else                                   e_an = 2'b01;
    check("sel",      8'(bus_if.sel),      8'(slot));
    check("an_n",     8'(bus_if.an_n),     8'(e_an));
    check("tick",     8'(bus_if.tick),     8'(pos == P - 1));
    check("a",        8'(bus_if.a),        8'(m_disp[3:0]));
    check("b",        8'(bus_if.b),        8'(m_disp[7:4]));
    check("load_ack", 8'(bus_if.load_ack), 8'(m_ack));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input logic ld, input logic [7:0] v, input logic lz);
    bus_if.load     = ld;
    bus_if.value    = v;
    bus_if.lz_blank = lz;
    m_lz            = lz;
    #1;
    check_model();
    @(posedge clk);
    if (((t + 1) % (2 * P)) == 0 && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (ld) begin
      m_pend = v;
      m_pv   = 1'b1;
    end
    m_ack = ld;
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), lz);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus_if.load = 1'b0;
    #1;
    check("rst_sel",  8'(bus_if.sel),      8'h00);
    check("rst_an_n", 8'(bus_if.an_n),     8'h03);
    check("rst_a",    8'(bus_if.a),        8'h00);
    check("rst_b",    8'(bus_if.b),        8'h00);
    check("rst_ack",  8'(bus_if.load_ack), 8'h00);
    check("rst_tick", 8'(bus_if.tick),     8'h00);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    t      = 0;
    m_disp = 8'h00;
    m_pend = 8'h00;
    m_pv   = 1'b0;
    m_ack  = 1'b0;
  endtask

  initial begin
    logic       ld;
    logic [7:0] v;
    bus_if.load     = 1'b0;
    bus_if.value    = 8'h00;
    bus_if.lz_blank = 1'b0;
    t    = 0;
    m_lz = 1'b0;
    @(negedge clk);
    apply_reset();

    // Single load mid-frame; shown from the next frame boundary.
    idle(3, 1'b0);
    cycle(1'b1, 8'h3A, 1'b0);
    idle(12, 1'b0);
    check("a_3A", 8'(bus_if.a), 8'h0A);
    check("b_3A", 8'(bus_if.b), 8'h03);

    // Back-to-back loads: latest wins.
    idle(5, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    idle(9, 1'b0);
    check("ab_34", {bus_if.b, bus_if.a}, 8'h34);

    // Load landing on the commit edge while another value is pending.
    idle(8, 1'b0);
    cycle(1'b1, 8'h78, 1'b0);
    idle(6, 1'b0);
    cycle(1'b1, 8'h56, 1'b0);
    check("ab_78", {bus_if.b, bus_if.a}, 8'h78);
    idle(16, 1'b0);
    check("ab_56", {bus_if.b, bus_if.a}, 8'h56);

    // Leading-zero blanking of digit 1.
    cycle(1'b1, 8'h07, 1'b1);
    idle(15 + 10, 1'b1);
    check("lz_on_an_n", 8'(bus_if.an_n), 8'h03);
    idle(16, 1'b0);
    check("lz_off_an_n", 8'(bus_if.an_n), 8'h01);
    idle(6, 1'b0);

    // Random loads, values and lz_blank.
    for (int i = 0; i < 320; i++) begin
      ld = ($urandom_range(0, 5) == 0);
      v  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v[7:4] = 4'h0;
      cycle(ld, v, 1'($urandom_range(0, 1)));
    end

    // Restart, then reset mid-frame with a value pending.
    apply_reset();
    idle(2, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0);
    idle(8, 1'b0);
    apply_reset();
    idle(16, 1'b0);
    check("discard_ab", {bus_if.b, bus_if.a}, 8'h00);
    idle(16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg_digit_scanner.md
Name: seg_digit_scanner

Overview:
- Time-multiplex controller for the two-digit seven-segment display. It sits directly upstream of the 4-bit 2:1 nibble mux (mux_array) and the segment decoder.
- Captures an 8-bit value through a load/ack handshake and double-buffers it so a frame is never torn.
- Drives the mux nibble inputs and its `sel`, plus active-low digit anodes, with a ghost-suppressing blank interval at the start of each digit slot.

Parameters:
- PRESCALE, 50000, clocks per digit slot; must be >= 2.
- BLANK, 16, clocks at the start of each slot with both anodes off; must satisfy 0 <= BLANK < PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  single-cycle request to capture `value`.
- value  in  8  display value; [3:0] is digit 0, [7:4] is digit 1.
- lz_blank  in  1  when 1, suppress digit 1 if its displayed nibble is 0.
- load_ack  out  1  one-cycle pulse acknowledging a load.
- a  out  4  displayed low nibble; drives mux input a (selected when sel=0).
- b  out  4  displayed high nibble; drives mux input b (selected when sel=1).
- sel  out  1  mux select: 0 selects digit 0, 1 selects digit 1.
- an_n  out  2  active-low anodes; an_n[0] is digit 0, an_n[1] is digit 1.
- tick  out  1  one-cycle pulse on the last clock of every slot.

Behaviour:
- Reset (async, rst_n=0): cnt=0; state=S_BLANK0; sel=0; an_n=2'b11; a=0; b=0; pending=0; pend_v=0; load_ack=0; tick=0. Reset mid-frame or mid-handshake abandons everything; the first slot after release starts at cnt=0.
- Slot counter: cnt runs 0..PRESCALE-1, then wraps to 0. tick=1 exactly when cnt==PRESCALE-1 (registered, aligned with that cycle).
- FSM, one state per slot phase:
  - S_BLANK0 (sel=0, an_n=11) -> S_SHOW0 when cnt==BLANK-1, or immediately when BLANK=0.
  - S_SHOW0 (sel=0, an_n=10) -> S_BLANK1 on wrap.
  - S_BLANK1 (sel=1, an_n=11) -> S_SHOW1 when cnt==BLANK-1.
  - S_SHOW1 (sel=1, an_n=01) -> S_BLANK0 on wrap.
- Frame length is 2*PRESCALE clocks.
- sel changes only on a slot boundary, so the mux output settles during the blank phase.
- Leading-zero blanking: in S_SHOW1, if lz_blank=1 and b==0, then an_n=11. lz_blank is sampled combinationally each cycle.
- Load handshake:
  - load=1 at edge N: pending<=value, pend_v<=1, load_ack=1 during cycle N+1.
  - Back-to-back loads: each load is acked and the latest value wins.
- Commit: on the S_SHOW1 -> S_BLANK0 transition with pend_v=1: {b,a}<=pending, pend_v<=0. a and b never change at any other time.
- Load on the same edge as a commit:
  - The commit uses the previously pending value.
  - The new value becomes pending with pend_v=1 and commits at the next frame boundary.
- Load with no prior pending value and no commit that edge: shown from the next frame boundary. Worst-case latency from load to display is 2*PRESCALE+BLANK clocks.
- All outputs are registered except the lz_blank gating of an_n.

Decomposition:
- Package seg_scan_pkg:
  - 2-bit state encoding S_BLANK0=0, S_SHOW0=1, S_BLANK1=2, S_SHOW1=3.
  - AN_OFF=2'b11, AN_D0=2'b10, AN_D1=2'b01.
  - Function clog2 for sizing cnt.
- Sub-module slot_timer (params PRESCALE, BLANK):
  - Outputs: cnt, blank_done (cnt==BLANK-1), wrap (cnt==PRESCALE-1).
  - The top level holds the FSM, buffering and handshake.

Test Plan (PRESCALE=8, BLANK=2):
- Reset release, no load -> an_n=11 for cycles 0-1, 10 for 2-7, 11 for 8-9, 01 for 10-15; sel=0 for 0-7 and 1 for 8-15; tick at cycles 7 and 15; a=b=0.
- load=1 with value=8'h3A at cycle 3 -> load_ack high at cycle 4; a/b stay 0 through cycle 15; at cycle 16 a=4'hA, b=4'h3.
- Loads of 8'h12 at cycle 5 and 8'h34 at cycle 6 -> two acks; frame at cycle 16 shows a=4, b=3; 12 is never displayed.
- Load 8'h56 landing on the commit edge (cycle 15 -> 16) while 8'h78 is pending -> 78 shown at cycle 16, 56 shown at cycle 32.
- lz_blank=1, value=8'h07 committed -> an_n stays 11 throughout S_SHOW1; with lz_blank=0, an_n=01.
- rst_n dropped at cycle 11 while pend_v=1 -> outputs immediately take reset values, pending is discarded, and the sequence restarts at cnt=0 after release.
